// File: rtl/rnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// rnn_layer_sequencer
//
// Frame-level controller for the RNN noise-suppression datapath. It accepts
// one feature frame and then starts the six layer engines in dependency order
// (dense1 -> gru1 -> dense2 -> gru2 -> gru3 -> dense3). It waits for each
// engine's done, flags when the VAD and gains outputs are valid, and runs a
// watchdog on every layer. It never touches datapath values.
//
// Optional build macro: RNN_SEQ_PARALLEL_VAD_EN
//   When defined, dense2 and gru2 run concurrently in a single state
//   (L_VAD_NOISE) that exits once both dones have been seen.
//
// Parameters
//   TIMEOUT_CYCLES : max non-entry cycles a layer may run before abort
//   TMR_W          : watchdog counter width, must hold TIMEOUT_CYCLES
//   FCNT_W         : completed-frame counter width
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   frame_valid  in   feature frame available
//   frame_ready  out  sequencer can accept a frame
//   clear_req    in   sampled at accept; request GRU hidden-state clear
//   layer_start  out  one-hot start pulse [0]d1 [1]g1 [2]d2 [3]g2 [4]g3 [5]d3
//   layer_done   in   engine done pulses, same bit order
//   state_clear  out  one-cycle pulse zeroing GRU hidden states
//   vad_valid    out  one-cycle pulse, dense2 VAD output valid
//   gains_valid  out  one-cycle pulse, dense3 gains output valid
//   busy         out  high whenever not IDLE
//   frame_cnt    out  completed frames, wraps modulo 2^FCNT_W
//   timeout_err  out  sticky watchdog error
//   err_clr      in   clears timeout_err (a simultaneous new timeout wins)
// ---------------------------------------------------------------------------
module rnn_layer_sequencer #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TMR_W          = 12,
    parameter int FCNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              clear_req,
    output logic [5:0]        layer_start,
    input  logic [5:0]        layer_done,
    output logic              state_clear,
    output logic              vad_valid,
    output logic              gains_valid,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              timeout_err,
    input  logic              err_clr
);

`ifdef RNN_SEQ_PARALLEL_VAD_EN
    typedef enum logic [2:0] {
        IDLE, L_DENSE1, L_GRU1, L_VAD_NOISE, L_GRU3, L_DENSE3, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, L_DENSE1, L_GRU1, L_DENSE2, L_GRU2, L_GRU3, L_DENSE3, DONE
    } state_t;
`endif

    state_t            r_state;
    logic              r_entry;          // first cycle of a layer state
    logic [TMR_W-1:0]  r_tmr;
    logic              r_rdy_en;         // low for the first cycle out of reset
    logic              r_pend_clear;
    logic              r_clear_after_err;
    logic              r_timeout_err;
    logic [FCNT_W-1:0] r_frame_cnt;

    state_t            w_next;
    state_t            w_next_lay;
    logic [5:0]        w_mask;
    logic              w_in_layer;
    logic              w_done_hit;
    logic              w_timeout;
    logic              w_accept;
    logic              w_enter;

`ifdef RNN_SEQ_PARALLEL_VAD_EN
    logic              r_got_d2;
    logic              r_got_g2;
    logic              r_vad_pend;
`endif

    always_comb begin
        w_mask      = '0;
        w_in_layer  = 1'b0;
        w_next_lay  = IDLE;
        w_next      = r_state;
        w_done_hit  = 1'b0;
        w_timeout   = 1'b0;
        w_accept    = 1'b0;
        w_enter     = 1'b0;
        frame_ready = 1'b0;
        gains_valid = 1'b0;
        busy        = (r_state != IDLE);

        // Which engine(s) the current state owns and where it goes next.
        case (r_state)
            L_DENSE1: begin w_mask = 6'b000001; w_in_layer = 1'b1; w_next_lay = L_GRU1;   end
`ifdef RNN_SEQ_PARALLEL_VAD_EN
            L_GRU1:      begin w_mask = 6'b000010; w_in_layer = 1'b1; w_next_lay = L_VAD_NOISE; end
            L_VAD_NOISE: begin w_mask = 6'b001100; w_in_layer = 1'b1; w_next_lay = L_GRU3;      end
`else
            L_GRU1:   begin w_mask = 6'b000010; w_in_layer = 1'b1; w_next_lay = L_DENSE2; end
            L_DENSE2: begin w_mask = 6'b000100; w_in_layer = 1'b1; w_next_lay = L_GRU2;   end
            L_GRU2:   begin w_mask = 6'b001000; w_in_layer = 1'b1; w_next_lay = L_GRU3;   end
`endif
            L_GRU3:   begin w_mask = 6'b010000; w_in_layer = 1'b1; w_next_lay = L_DENSE3; end
            L_DENSE3: begin w_mask = 6'b100000; w_in_layer = 1'b1; w_next_lay = DONE;     end
            default: ;
        endcase

        // Done is ignored in the entry cycle; bits of other layers never match the mask.
`ifdef RNN_SEQ_PARALLEL_VAD_EN
        if (r_state == L_VAD_NOISE)
            w_done_hit = !r_entry && (r_got_d2 || layer_done[2]) && (r_got_g2 || layer_done[3]);
        else
            w_done_hit = w_in_layer && !r_entry && (|(layer_done & w_mask));
`else
        w_done_hit = w_in_layer && !r_entry && (|(layer_done & w_mask));
`endif
        // r_tmr counts completed non-entry cycles, so this fires on the
        // TIMEOUT_CYCLES-th non-entry cycle; a done in that cycle still wins.
        w_timeout = w_in_layer && !r_entry && !w_done_hit &&
                    (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
        w_accept  = (r_state == IDLE) && r_rdy_en && frame_valid;

        case (r_state)
            IDLE: begin
                frame_ready = r_rdy_en;
                if (w_accept) w_next = L_DENSE1;
            end
            DONE: begin
                gains_valid = 1'b1;
                w_next      = IDLE;
            end
            default: begin
                if (w_done_hit)     w_next = w_next_lay;
                else if (w_timeout) w_next = IDLE;
            end
        endcase

        w_enter     = (w_next != r_state) && (w_next != IDLE) && (w_next != DONE);
        layer_start = r_entry ? w_mask : 6'b000000;
        state_clear = (r_state == L_DENSE1) && r_entry && r_pend_clear;
`ifdef RNN_SEQ_PARALLEL_VAD_EN
        vad_valid   = r_vad_pend;
`else
        vad_valid   = (r_state == L_GRU2) && r_entry;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_entry           <= 1'b0;
            r_tmr             <= '0;
            r_rdy_en          <= 1'b0;
            r_pend_clear      <= 1'b0;
            r_clear_after_err <= 1'b0;
            r_timeout_err     <= 1'b0;
            r_frame_cnt       <= '0;
        end else begin
            r_state  <= w_next;
            r_entry  <= w_enter;
            r_rdy_en <= 1'b1;

            if (r_entry)         r_tmr <= '0;
            else if (w_in_layer) r_tmr <= r_tmr + 1'b1;

            // A clear pending from the last timeout rides on the next frame.
            if (w_accept)
                r_pend_clear <= clear_req | r_clear_after_err;
            else if (state_clear)
                r_pend_clear <= 1'b0;

            if (w_timeout)
                r_clear_after_err <= 1'b1;
            else if ((r_state == L_DENSE1) && r_entry)
                r_clear_after_err <= 1'b0;

            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (err_clr) r_timeout_err <= 1'b0;

            if (r_state == DONE) r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

`ifdef RNN_SEQ_PARALLEL_VAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_got_d2   <= 1'b0;
            r_got_g2   <= 1'b0;
            r_vad_pend <= 1'b0;
        end else begin
            if (r_entry) begin
                r_got_d2 <= 1'b0;
                r_got_g2 <= 1'b0;
            end else if (r_state == L_VAD_NOISE) begin
                if (layer_done[2]) r_got_d2 <= 1'b1;
                if (layer_done[3]) r_got_g2 <= 1'b1;
            end
            // VAD is valid the cycle after dense2's done is first seen.
            r_vad_pend <= (r_state == L_VAD_NOISE) && !r_entry && layer_done[2] &&
                          !r_got_d2 && !w_timeout;
        end
    end
`endif

    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/rnn_layer_sequencer.md
Name: rnn_layer_sequencer

Overview:
- Frame-level controller for the RNN noise-suppression datapath.
- Accepts one feature frame, then issues start pulses to the six layer engines in dependency order: dense1 → gru1 → dense2 → gru2 → gru3 → dense3.
- Waits on each engine's done, flags VAD and gains availability, and guards every layer with a watchdog.
- Sits between the frame/feature front end and the layer engines; it does not touch datapath values.

Parameters:
- TIMEOUT_CYCLES, 4095: max cycles a layer may run after its start pulse before abort.
- TMR_W, 12: width of the watchdog counter; must hold TIMEOUT_CYCLES.
- FCNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_valid  in  1  feature frame available.
- frame_ready  out  1  sequencer can accept a frame.
- clear_req  in  1  sampled at frame accept; requests a GRU hidden-state clear.
- layer_start  out  6  one-hot start pulse. Bit order: [0]dense1 [1]gru1 [2]dense2 [3]gru2 [4]gru3 [5]dense3.
- layer_done  in  6  done pulses from the engines, same bit order.
- state_clear  out  1  one-cycle pulse that zeroes the GRU hidden states.
- vad_valid  out  1  one-cycle pulse: dense2 vad output is valid.
- gains_valid  out  1  one-cycle pulse: dense3 gains output is valid.
- busy  out  1  high whenever not IDLE.
- frame_cnt  out  FCNT_W  count of completed frames.
- timeout_err  out  1  sticky watchdog error.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset: state IDLE. All outputs 0, including frame_ready, frame_cnt and timeout_err. frame_ready rises the first cycle after rst deasserts. rst asserted mid-frame aborts immediately; no start, valid or clear pulses are emitted afterwards.
- States: IDLE, L_DENSE1, L_GRU1, L_DENSE2, L_GRU2, L_GRU3, L_DENSE3, DONE.
- IDLE:
  - frame_ready=1.
  - Accept when frame_valid && frame_ready, then go to L_DENSE1.
  - Latch pend_clear = clear_req | clear_after_err.
- Layer state:
  - The entry cycle drives layer_start[k]=1 for exactly one cycle and resets the watchdog to 0.
  - layer_done[k] is honoured in any later cycle of the state; done in the entry cycle is ignored.
  - done bits for other layers are ignored.
  - On an honoured done, the next cycle is the entry cycle of the next state.
- state_clear: pulses in the L_DENSE1 entry cycle if pend_clear is set. pend_clear and clear_after_err then clear.
- vad_valid: pulses in the cycle after the dense2 done, which is the L_GRU2 entry cycle.
- DONE: lasts one cycle.
  - gains_valid=1.
  - frame_cnt increments, wrapping modulo 2^FCNT_W.
  - Next state IDLE.
- Watchdog:
  - Increments every non-entry cycle of a layer state.
  - If it reaches TIMEOUT_CYCLES without done: set timeout_err, set clear_after_err, go to IDLE.
  - No gains_valid is produced and frame_cnt is unchanged.
- timeout_err clears only on rst, or on err_clr when no new timeout fires in the same cycle; a new timeout wins.
- Latency: with every engine returning done D cycles after its start, frame accept at cycle 0 gives gains_valid at cycle 6·(D+1)+1.

Optional Feature:
- Macro: RNN_SEQ_PARALLEL_VAD_EN.
- When defined:
  - L_DENSE2 and L_GRU2 merge into one state L_VAD_NOISE.
  - Its entry cycle pulses layer_start[2] and layer_start[3] together.
  - Each done is latched independently; the state exits once both are latched, in either order or in the same cycle.
  - vad_valid pulses the cycle after dense2's done is first latched.
  - The watchdog covers the state as a whole.
  - Latency becomes 5·(D+1)+1 when all D are equal.
- When undefined: strictly serial order as described above.

Test Plan:
- Basic serial frame: engine model with D=3, frame accept at cycle 0. Require start pulses at cycles 1, 5, 9, 13, 17, 21; vad_valid at 13; gains_valid at 25; frame_ready back at 26; frame_cnt=1.
- Parallel build (RNN_SEQ_PARALLEL_VAD_EN): D=3, except gru2 done at D=5. Require layer_start[2] and [3] both at cycle 9; vad_valid at 13; gru3 start at 15; gains_valid at 23.
- Watchdog: TIMEOUT_CYCLES=8, gru1 never returns done. Require timeout_err=1 eight non-entry cycles after the gru1 start, return to IDLE, no gains_valid, frame_cnt unchanged. The next accepted frame pulses state_clear in its dense1 entry cycle.
- Done handling: done[1] raised in the same cycle as the gru1 start, plus a spurious done[4] during gru1. Neither advances the state; a later done[1] does.
- Reset mid-frame: assert rst during L_GRU2. Require all outputs 0 next cycle, frame_ready=1 the cycle after rst drops, and the following frame completes normally.
- Counter wrap and error clear: preload 65535 completed frames, complete one more → frame_cnt=0. err_clr asserted in the same cycle as a new timeout → timeout_err stays 1.
